decode_stage_fwd: RTL and testbench

//  Parametrised successor decode stage: reads rs1/rs2, generates the immediate and registers operands into the DE->EXE latch.

---
 rtl/riscv_dec_pkg.sv | 37 +++
 rtl/imm_gen.sv | 28 ++
 rtl/register_file.sv | 39 +++
 rtl/decode_stage_fwd.sv | 161 ++++++++++++++++
 tb/tb_decode_stage_fwd.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_dec_pkg.sv
// rtl/riscv_dec_pkg.sv - opcode constants and immediate-type helpers for the decode stage
package riscv_dec_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  // Each opcode needs exactly one immediate format; anything unrecognised uses I.
  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OPC_STORE:           t = IMM_S;
      OPC_BRANCH:          t = IMM_B;
      OPC_LUI, OPC_AUIPC:  t = IMM_U;
      OPC_JAL:             t = IMM_J;
      default:             t = IMM_I;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - sign-extended immediate extraction from the instruction word
module imm_gen
  import riscv_dec_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:7]     IR,
  input  imm_type_e       SEL,
  output logic [XLEN-1:0] IMM
);

  logic signed [31:0] imm32;

  // Assemble the 32-bit form, then the signed size cast extends to XLEN
  always_comb begin
    imm32 = '0;
    case (SEL)
      IMM_I:   imm32 = {{20{IR[31]}}, IR[31:20]};
      IMM_S:   imm32 = {{20{IR[31]}}, IR[31:25], IR[11:7]};
      IMM_B:   imm32 = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
      IMM_U:   imm32 = {IR[31:12], 12'b0};
      IMM_J:   imm32 = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    IMM = XLEN'(imm32);
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register file with write-through reads and hardwired x0
module register_file #(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [RW-1:0]   RD_ADDR1,
  input  logic [RW-1:0]   RD_ADDR2,
  output logic [XLEN-1:0] RD_DATA1,
  output logic [XLEN-1:0] RD_DATA2,
  input  logic [RW-1:0]   WR_ADDR,
  input  logic [XLEN-1:0] WR_DATA,
  input  logic            WR_EN
);

  logic [XLEN-1:0] regs [NREGS];

  // Write port: cleared on reset, x0 is never stored
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (WR_EN && (WR_ADDR != '0)) begin
      regs[WR_ADDR] <= WR_DATA;
    end
  end

  // Read ports: x0 reads zero, a same-cycle write to the index is passed straight through
  always_comb begin
    RD_DATA1 = regs[RD_ADDR1];
    RD_DATA2 = regs[RD_ADDR2];
    if (WR_EN && (WR_ADDR == RD_ADDR1)) RD_DATA1 = WR_DATA;
    if (WR_EN && (WR_ADDR == RD_ADDR2)) RD_DATA2 = WR_DATA;
    if (RD_ADDR1 == '0) RD_DATA1 = '0;
    if (RD_ADDR2 == '0) RD_DATA2 = '0;
  end

endmodule

// File: rtl/decode_stage_fwd.sv
// rtl/decode_stage_fwd.sv - decode stage with EXE/MEM/WB forwarding, load-use stall and flush
module decode_stage_fwd
  import riscv_dec_pkg::*;
#(
  parameter  int XLEN   = 64,
  parameter  int NREGS  = 32,
  parameter  int FWD_EN = 1,
  localparam int RW     = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            DE_V,
  input  logic [XLEN-1:0] DE_NPC,
  input  logic [31:0]     DE_IR,
  input  logic            FLUSH,
  input  logic [RW-1:0]   EXE_DR,
  input  logic [RW-1:0]   MEM_DR,
  input  logic [RW-1:0]   WB_DR,
  input  logic            EXE_V,
  input  logic            MEM_V,
  input  logic            WB_V,
  input  logic            EXE_IS_LOAD,
  input  logic [XLEN-1:0] EXE_FWD,
  input  logic [XLEN-1:0] MEM_FWD,
  input  logic [XLEN-1:0] WB_FWD,
  input  logic [RW-1:0]   OUT_DE_DR,
  input  logic [XLEN-1:0] OUT_DE_Data,
  input  logic            OUT_DE_REG_WEN,
  output logic [XLEN-1:0] ALU1,
  output logic [XLEN-1:0] ALU2,
  output logic [XLEN-1:0] STORE_DATA,
  output logic [XLEN-1:0] TARGET_ADDRESS,
  output logic [XLEN-1:0] MEM_ADDRESS,
  output logic [31:0]     EXE_IR,
  output logic [XLEN-1:0] EXE_NPC,
  output logic            EXE_Vout,
  output logic            stall,
  output logic            V_DE_FE_BR_STALL,
  output logic [3:0]      EXE_Cst
);

  logic [6:0]      opcode;
  logic [RW-1:0]   rs1, rs2;
  logic            use_rs1, use_rs2;
  logic            exe_m1, exe_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic            hazard;
  logic [XLEN-1:0] rf1, rf2, f1, f2, imm;
  logic [XLEN-1:0] alu1_d, alu2_d, sd_d, tgt_d, maddr_d;

  assign opcode  = DE_IR[6:0];
  assign rs1     = DE_IR[15 +: RW];
  assign rs2     = DE_IR[20 +: RW];
  assign EXE_Cst = 4'b0;

  register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .CLK      (CLK),
    .RESET    (RESET),
    .RD_ADDR1 (rs1),
    .RD_ADDR2 (rs2),
    .RD_DATA1 (rf1),
    .RD_DATA2 (rf2),
    .WR_ADDR  (OUT_DE_DR),
    .WR_DATA  (OUT_DE_Data),
    .WR_EN    (OUT_DE_REG_WEN)
  );

  imm_gen #(.XLEN(XLEN)) u_imm (
    .IR  (DE_IR[31:7]),
    .SEL (imm_type_of(opcode)),
    .IMM (imm)
  );

  // Source usage, per-stage matches (x0 never matches) and the resulting hazard
  always_comb begin
    use_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH) ||
              ((XLEN == 64) && (opcode == OPC_OP_32));
    exe_m1  = EXE_V && (EXE_DR == rs1) && (rs1 != '0);
    exe_m2  = EXE_V && (EXE_DR == rs2) && (rs2 != '0);
    mem_m1  = MEM_V && (MEM_DR == rs1) && (rs1 != '0);
    mem_m2  = MEM_V && (MEM_DR == rs2) && (rs2 != '0);
    wb_m1   = WB_V  && (WB_DR  == rs1) && (rs1 != '0);
    wb_m2   = WB_V  && (WB_DR  == rs2) && (rs2 != '0);
    if (FWD_EN != 0) begin
      hazard = DE_V && EXE_IS_LOAD && ((use_rs1 && exe_m1) || (use_rs2 && exe_m2));
    end else begin
      hazard = DE_V && ((use_rs1 && (exe_m1 || mem_m1 || wb_m1)) ||
                        (use_rs2 && (exe_m2 || mem_m2 || wb_m2)));
    end
    stall = hazard && !FLUSH;
    V_DE_FE_BR_STALL = DE_V && ((DE_IR[6:2] == 5'b11000) || (DE_IR[6:2] == 5'b11001) ||
                                (DE_IR[6:2] == 5'b11011));
  end

  // Operand forwarding, youngest stage first; without forwarding any match stalls instead
  always_comb begin
    f1 = rf1;
    f2 = rf2;
    if (FWD_EN != 0) begin
      if (exe_m1)      f1 = EXE_FWD;
      else if (mem_m1) f1 = MEM_FWD;
      else if (wb_m1)  f1 = WB_FWD;
      if (exe_m2)      f2 = EXE_FWD;
      else if (mem_m2) f2 = MEM_FWD;
      else if (wb_m2)  f2 = WB_FWD;
    end
  end

  // Per-opcode operand, store-data and address generation
  always_comb begin
    alu1_d  = '0;
    alu2_d  = '0;
    sd_d    = '0;
    tgt_d   = '0;
    maddr_d = '0;
    case (opcode)
      OPC_LOAD:   begin alu1_d = f1; alu2_d = imm; maddr_d = f1 + imm; end
      OPC_STORE:  begin alu1_d = f1; alu2_d = imm; sd_d = f2; maddr_d = f1 + imm; end
      OPC_OP:     begin alu1_d = f1; alu2_d = f2; end
      OPC_OP_IMM: begin alu1_d = f1; alu2_d = imm; end
      OPC_BRANCH: begin alu1_d = f1; alu2_d = f2; tgt_d = DE_NPC + imm; end
      OPC_LUI:    begin alu1_d = imm; end
      OPC_AUIPC:  begin alu1_d = DE_NPC; alu2_d = imm; end
      OPC_JAL:    begin alu1_d = DE_NPC; alu2_d = XLEN'(4); tgt_d = DE_NPC + imm; end
      OPC_JALR:   begin alu1_d = DE_NPC; alu2_d = XLEN'(4); tgt_d = (f1 + imm) & ~XLEN'(1); end
      OPC_OP_32: begin
        if (XLEN == 64) begin alu1_d = f1; alu2_d = f2; end
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin alu1_d = f1; alu2_d = imm; end
      end
      default: ;
    endcase
  end

  // DE->EXE latch: reset clears, flush or hazard injects a bubble and holds, otherwise load
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ALU1           <= '0;
      ALU2           <= '0;
      STORE_DATA     <= '0;
      TARGET_ADDRESS <= '0;
      MEM_ADDRESS    <= '0;
      EXE_IR         <= '0;
      EXE_NPC        <= '0;
      EXE_Vout       <= 1'b0;
    end else if (FLUSH || hazard) begin
      EXE_Vout       <= 1'b0;
    end else begin
      ALU1           <= alu1_d;
      ALU2           <= alu2_d;
      STORE_DATA     <= sd_d;
      TARGET_ADDRESS <= tgt_d;
      MEM_ADDRESS    <= maddr_d;
      EXE_IR         <= DE_IR;
      EXE_NPC        <= DE_NPC;
      EXE_Vout       <= DE_V;
    end
  end

endmodule

// File: tb/tb_decode_stage_fwd.sv
// tb/tb_decode_stage_fwd.sv - self-checking bench for decode_stage_fwd (64-bit forwarding and 32-bit stalling builds)
module tb_decode_stage_fwd;

  localparam logic [6:0] LD = 7'h03, ST = 7'h23, OPR = 7'h33, OPI = 7'h13, BR = 7'h63;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
  localparam logic [6:0] OP32 = 7'h3B, OPI32 = 7'h1B, UNK = 7'h0F;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET, DE_V, FLUSH, EXE_V, MEM_V, WB_V, EXE_IS_LOAD, OUT_DE_REG_WEN;
  logic [63:0] DE_NPC, EXE_FWD, MEM_FWD, WB_FWD, OUT_DE_Data;
  logic [31:0] DE_IR;
  logic [4:0]  EXE_DR, MEM_DR, WB_DR, OUT_DE_DR;

  logic [63:0] a_alu1, a_alu2, a_sd, a_tgt, a_maddr, a_npc;
  logic [31:0] a_ir;
  logic        a_v, a_stall, a_br;
  logic [3:0]  a_cst;
  logic [31:0] b_alu1, b_alu2, b_sd, b_tgt, b_maddr, b_npc, b_ir;
  logic        b_v, b_stall, b_br;
  logic [3:0]  b_cst;

  decode_stage_fwd dut64 (
    .CLK(CLK), .RESET(RESET), .DE_V(DE_V), .DE_NPC(DE_NPC), .DE_IR(DE_IR), .FLUSH(FLUSH),
    .EXE_DR(EXE_DR), .MEM_DR(MEM_DR), .WB_DR(WB_DR), .EXE_V(EXE_V), .MEM_V(MEM_V), .WB_V(WB_V),
    .EXE_IS_LOAD(EXE_IS_LOAD), .EXE_FWD(EXE_FWD), .MEM_FWD(MEM_FWD), .WB_FWD(WB_FWD),
    .OUT_DE_DR(OUT_DE_DR), .OUT_DE_Data(OUT_DE_Data), .OUT_DE_REG_WEN(OUT_DE_REG_WEN),
    .ALU1(a_alu1), .ALU2(a_alu2), .STORE_DATA(a_sd), .TARGET_ADDRESS(a_tgt), .MEM_ADDRESS(a_maddr),
    .EXE_IR(a_ir), .EXE_NPC(a_npc), .EXE_Vout(a_v), .stall(a_stall), .V_DE_FE_BR_STALL(a_br),
    .EXE_Cst(a_cst)
  );

  decode_stage_fwd #(.XLEN(32), .NREGS(32), .FWD_EN(0)) dut32 (
    .CLK(CLK), .RESET(RESET), .DE_V(DE_V), .DE_NPC(DE_NPC[31:0]), .DE_IR(DE_IR), .FLUSH(FLUSH),
    .EXE_DR(EXE_DR), .MEM_DR(MEM_DR), .WB_DR(WB_DR), .EXE_V(EXE_V), .MEM_V(MEM_V), .WB_V(WB_V),
    .EXE_IS_LOAD(EXE_IS_LOAD), .EXE_FWD(EXE_FWD[31:0]), .MEM_FWD(MEM_FWD[31:0]), .WB_FWD(WB_FWD[31:0]),
    .OUT_DE_DR(OUT_DE_DR), .OUT_DE_Data(OUT_DE_Data[31:0]), .OUT_DE_REG_WEN(OUT_DE_REG_WEN),
    .ALU1(b_alu1), .ALU2(b_alu2), .STORE_DATA(b_sd), .TARGET_ADDRESS(b_tgt), .MEM_ADDRESS(b_maddr),
    .EXE_IR(b_ir), .EXE_NPC(b_npc), .EXE_Vout(b_v), .stall(b_stall), .V_DE_FE_BR_STALL(b_br),
    .EXE_Cst(b_cst)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 = 64-bit forwarding build, index 1 = 32-bit stalling build
  longint unsigned mregs [32];
  longint unsigned m_alu1 [2], m_alu2 [2], m_sd [2], m_tgt [2], m_maddr [2], m_npc [2];
  logic [31:0]     m_ir [2];
  logic            m_v [2];

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] r1,
                                        input logic [4:0] r2, input logic [6:0] op);
    return {7'd0, r2, r1, 3'd0, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, r1, 3'd0, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r1,
                                        input logic [4:0] r2);
    return {imm[12], imm[10:5], r2, r1, 3'd0, imm[4:1], imm[11], BR};
  endfunction

  function automatic bit uses1(input logic [6:0] op);
    return !(op == LUI || op == AUIPC || op == JAL);
  endfunction

  function automatic bit uses2(input logic [6:0] op, input int k);
    return op == OPR || op == ST || op == BR || (k == 0 && op == OP32);
  endfunction

  function automatic bit hit(input logic [4:0] r, input int k);
    if (r == 0) return 1'b0;
    if (k == 0) return EXE_V && EXE_IS_LOAD && EXE_DR == r;
    return (EXE_V && EXE_DR == r) || (MEM_V && MEM_DR == r) || (WB_V && WB_DR == r);
  endfunction

  function automatic bit model_hazard(input int k);
    logic [6:0] op;
    op = DE_IR[6:0];
    return DE_V && ((uses1(op) && hit(DE_IR[19:15], k)) || (uses2(op, k) && hit(DE_IR[24:20], k)));
  endfunction

  function automatic bit model_br();
    return DE_V && (DE_IR[6:2] == 5'b11000 || DE_IR[6:2] == 5'b11001 || DE_IR[6:2] == 5'b11011);
  endfunction

  function automatic longint unsigned src(input logic [4:0] r, input int k);
    if (r == 0) return 0;
    if (k == 0) begin
      if (EXE_V && EXE_DR == r) return EXE_FWD;
      if (MEM_V && MEM_DR == r) return MEM_FWD;
      if (WB_V && WB_DR == r) return WB_FWD;
    end
    if (OUT_DE_REG_WEN && OUT_DE_DR == r) return OUT_DE_Data;
    return mregs[r];
  endfunction

  // Advance one clock: predict from current inputs, take the edge, commit, settle
  task automatic step();
    longint unsigned n_alu1 [2], n_alu2 [2], n_sd [2], n_tgt [2], n_maddr [2], n_npc [2];
    logic [31:0] n_ir [2];
    logic        n_v [2];
    for (int k = 0; k < 2; k++) begin
      longint unsigned mask, f1, f2, i_i, i_s, i_b, i_u, i_j, x1, x2, sd, tg, ma;
      logic [6:0] op;
      mask = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      op   = DE_IR[6:0];
      f1   = src(DE_IR[19:15], k);
      f2   = src(DE_IR[24:20], k);
      i_i  = longint'($signed(DE_IR[31:20]));
      i_s  = longint'($signed({DE_IR[31:25], DE_IR[11:7]}));
      i_b  = longint'($signed({DE_IR[31], DE_IR[7], DE_IR[30:25], DE_IR[11:8], 1'b0}));
      i_u  = longint'($signed({DE_IR[31:12], 12'b0}));
      i_j  = longint'($signed({DE_IR[31], DE_IR[19:12], DE_IR[20], DE_IR[30:21], 1'b0}));
      x1 = 0; x2 = 0; sd = 0; tg = 0; ma = 0;
      case (op)
        LD:    begin x1 = f1; x2 = i_i; ma = f1 + i_i; end
        ST:    begin x1 = f1; x2 = i_s; sd = f2; ma = f1 + i_s; end
        OPR:   begin x1 = f1; x2 = f2; end
        OPI:   begin x1 = f1; x2 = i_i; end
        BR:    begin x1 = f1; x2 = f2; tg = DE_NPC + i_b; end
        LUI:   begin x1 = i_u; end
        AUIPC: begin x1 = DE_NPC; x2 = i_u; end
        JAL:   begin x1 = DE_NPC; x2 = 4; tg = DE_NPC + i_j; end
        JALR:  begin x1 = DE_NPC; x2 = 4; tg = (f1 + i_i) & ~64'd1; end
        OP32:  if (k == 0) begin x1 = f1; x2 = f2; end
        OPI32: if (k == 0) begin x1 = f1; x2 = i_i; end
        default: ;
      endcase
      n_alu1[k] = m_alu1[k]; n_alu2[k] = m_alu2[k]; n_sd[k] = m_sd[k]; n_tgt[k] = m_tgt[k];
      n_maddr[k] = m_maddr[k]; n_npc[k] = m_npc[k]; n_ir[k] = m_ir[k]; n_v[k] = m_v[k];
      if (RESET) begin
        n_alu1[k] = 0; n_alu2[k] = 0; n_sd[k] = 0; n_tgt[k] = 0; n_maddr[k] = 0;
        n_npc[k] = 0; n_ir[k] = '0; n_v[k] = 1'b0;
      end else if (FLUSH || model_hazard(k)) begin
        n_v[k] = 1'b0;
      end else begin
        n_alu1[k] = x1 & mask; n_alu2[k] = x2 & mask; n_sd[k] = sd & mask; n_tgt[k] = tg & mask;
        n_maddr[k] = ma & mask; n_npc[k] = DE_NPC & mask; n_ir[k] = DE_IR; n_v[k] = DE_V;
      end
    end
    @(posedge CLK);
    if (RESET) begin
      for (int i = 0; i < 32; i++) mregs[i] = 0;
    end else if (OUT_DE_REG_WEN && OUT_DE_DR != 0) begin
      mregs[OUT_DE_DR] = OUT_DE_Data;
    end
    m_alu1 = n_alu1; m_alu2 = n_alu2; m_sd = n_sd; m_tgt = n_tgt;
    m_maddr = n_maddr; m_npc = n_npc; m_ir = n_ir; m_v = n_v;
    #1;
  endtask

  task automatic idle_inputs();
    DE_V = 0; FLUSH = 0; EXE_V = 0; MEM_V = 0; WB_V = 0; EXE_IS_LOAD = 0; OUT_DE_REG_WEN = 0;
    EXE_DR = 0; MEM_DR = 0; WB_DR = 0; OUT_DE_DR = 0; OUT_DE_Data = 0;
    EXE_FWD = 0; MEM_FWD = 0; WB_FWD = 0; DE_NPC = 0; DE_IR = 0;
  endtask

  task automatic test_reset();
    RESET = 1; DE_V = 1; FLUSH = 1; DE_IR = enc_r(5'd6, 5'd5, 5'd5, OPR); DE_NPC = 64'h40;
    step(); step();
    n_checks++;
    if ({a_v, a_ir, a_npc, a_alu1, a_alu2, a_sd, a_tgt, a_maddr, a_cst} !== '0) begin
      n_fail++; $display("FAIL reset64: got v=%b ir=%h alu1=%h alu2=%h cst=%h, want all 0", a_v, a_ir, a_alu1, a_alu2, a_cst);
    end
    n_checks++;
    if ({b_v, b_ir, b_npc, b_alu1, b_alu2, b_sd, b_tgt, b_maddr, b_cst} !== '0) begin
      n_fail++; $display("FAIL reset32: got v=%b ir=%h alu1=%h alu2=%h cst=%h, want all 0", b_v, b_ir, b_alu1, b_alu2, b_cst);
    end
    RESET = 0; DE_V = 0; FLUSH = 0;
    step();
    n_checks++;
    if ({a_v, b_v} !== 2'b00) begin
      n_fail++; $display("FAIL release_v: got %b%b, want 00", a_v, b_v);
    end
  endtask

  task automatic test_exe_forward();
    OUT_DE_REG_WEN = 1; OUT_DE_DR = 5; OUT_DE_Data = 10; DE_V = 0;
    step();
    OUT_DE_REG_WEN = 0;
    EXE_V = 1; EXE_DR = 5; EXE_FWD = 99; DE_V = 1; DE_IR = enc_r(5'd6, 5'd5, 5'd5, OPR);
    #1;
    n_checks++;
    if ({a_stall, b_stall} !== 2'b01) begin
      n_fail++; $display("FAIL exe_fwd_stall: got a=%b b=%b, want a=0 b=1", a_stall, b_stall);
    end
    step();
    n_checks++;
    if (a_alu1 !== 64'd99 || a_alu2 !== 64'd99 || a_v !== 1'b1 || b_v !== 1'b0) begin
      n_fail++; $display("FAIL exe_fwd_ops: got alu1=%0d alu2=%0d v=%b bv=%b, want 99 99 1 0", a_alu1, a_alu2, a_v, b_v);
    end
    EXE_V = 0; DE_IR = enc_i(12'd16, 5'd5, 5'd2, LD);
    #1;
    step();
    n_checks++;
    if (a_alu1 !== 64'd10 || a_maddr !== 64'd26 || b_maddr !== 32'd26 || b_v !== 1'b1) begin
      n_fail++; $display("FAIL rf_load: got alu1=%0d maddr=%0d bmaddr=%0d bv=%b, want 10 26 26 1", a_alu1, a_maddr, b_maddr, b_v);
    end
    OUT_DE_REG_WEN = 1; OUT_DE_DR = 5; OUT_DE_Data = 20;
    step();
    OUT_DE_REG_WEN = 0;
    n_checks++;
    if (a_maddr !== 64'd36 || b_maddr !== 32'd36) begin
      n_fail++; $display("FAIL write_through: got %0d/%0d, want 36/36", a_maddr, b_maddr);
    end
  endtask

  task automatic test_priority();
    EXE_V = 1; MEM_V = 1; WB_V = 1; EXE_DR = 7; MEM_DR = 7; WB_DR = 7;
    EXE_FWD = 1; MEM_FWD = 2; WB_FWD = 3; DE_V = 1; DE_IR = enc_r(5'd8, 5'd7, 5'd0, OPR);
    step();
    n_checks++;
    if (a_alu1 !== 64'd1 || a_alu2 !== 64'd0) begin
      n_fail++; $display("FAIL prio_exe: got alu1=%0d alu2=%0d, want 1 0", a_alu1, a_alu2);
    end
    EXE_V = 0;
    step();
    n_checks++;
    if (a_alu1 !== 64'd2) begin
      n_fail++; $display("FAIL prio_mem: got %0d, want 2", a_alu1);
    end
    MEM_V = 0;
    step();
    n_checks++;
    if (a_alu1 !== 64'd3) begin
      n_fail++; $display("FAIL prio_wb: got %0d, want 3", a_alu1);
    end
    WB_V = 0;
    step();
    n_checks++;
    if (a_alu1 !== 64'd0) begin
      n_fail++; $display("FAIL prio_rf: got %0d, want 0", a_alu1);
    end
  endtask

  task automatic test_load_use();
    DE_V = 1; DE_IR = enc_i(12'd42, 5'd0, 5'd9, OPI);
    step();
    EXE_V = 1; EXE_IS_LOAD = 1; EXE_DR = 3; DE_IR = enc_i(12'd1, 5'd3, 5'd4, OPI);
    #1;
    n_checks++;
    if (a_stall !== 1'b1) begin
      n_fail++; $display("FAIL load_use_stall: got %b, want 1", a_stall);
    end
    step();
    n_checks++;
    if (a_v !== 1'b0 || a_alu2 !== 64'd42) begin
      n_fail++; $display("FAIL load_use_bubble: got v=%b alu2=%0d, want 0 42", a_v, a_alu2);
    end
    DE_IR = enc_i(12'd3, 5'd5, 5'd4, OPI);
    #1;
    n_checks++;
    if (a_stall !== 1'b0) begin
      n_fail++; $display("FAIL unused_rs2: got %b, want 0", a_stall);
    end
    DE_IR = enc_i(12'd0, 5'd3, 5'd4, LUI);
    #1;
    n_checks++;
    if (a_stall !== 1'b0) begin
      n_fail++; $display("FAIL lui_rs1: got %b, want 0", a_stall);
    end
    DE_IR = {7'd0, 5'd3, 5'd0, 3'b010, 5'd0, ST};
    #1;
    n_checks++;
    if (a_stall !== 1'b1) begin
      n_fail++; $display("FAIL store_rs2: got %b, want 1", a_stall);
    end
    EXE_V = 0; DE_IR = enc_i(12'd1, 5'd3, 5'd4, OPI);
    #1;
    step();
    n_checks++;
    if (a_v !== 1'b1 || a_alu2 !== 64'd1) begin
      n_fail++; $display("FAIL load_use_issue: got v=%b alu2=%0d, want 1 1", a_v, a_alu2);
    end
    EXE_IS_LOAD = 0;
  endtask

  task automatic test_x0_flush();
    EXE_V = 1; EXE_IS_LOAD = 1; EXE_DR = 0; EXE_FWD = 55; DE_V = 1; DE_IR = enc_i(12'd5, 5'd0, 5'd1, OPI);
    #1;
    n_checks++;
    if ({a_stall, b_stall} !== 2'b00) begin
      n_fail++; $display("FAIL x0_stall: got %b%b, want 00", a_stall, b_stall);
    end
    step();
    n_checks++;
    if (a_alu1 !== 64'd0 || a_alu2 !== 64'd5 || a_v !== 1'b1) begin
      n_fail++; $display("FAIL x0_ops: got alu1=%0d alu2=%0d v=%b, want 0 5 1", a_alu1, a_alu2, a_v);
    end
    EXE_DR = 3; DE_IR = enc_i(12'd1, 5'd3, 5'd4, OPI); FLUSH = 1;
    #1;
    n_checks++;
    if ({a_stall, b_stall} !== 2'b00) begin
      n_fail++; $display("FAIL flush_stall: got %b%b, want 00", a_stall, b_stall);
    end
    step();
    n_checks++;
    if ({a_v, b_v} !== 2'b00) begin
      n_fail++; $display("FAIL flush_v: got %b%b, want 00", a_v, b_v);
    end
    FLUSH = 0; EXE_V = 0; EXE_IS_LOAD = 0;
  endtask

  task automatic test_fwd_off_32();
    WB_V = 1; WB_DR = 9; DE_V = 1; DE_IR = enc_r(5'd10, 5'd0, 5'd9, OPR);
    #1;
    n_checks++;
    if ({a_stall, b_stall} !== 2'b01) begin
      n_fail++; $display("FAIL nofwd_wb_stall: got a=%b b=%b, want a=0 b=1", a_stall, b_stall);
    end
    WB_V = 0; DE_IR = enc_b(13'h1FF8, 5'd0, 5'd0); DE_NPC = 64'h100;
    #1;
    n_checks++;
    if ({a_br, b_br, b_stall} !== 3'b110) begin
      n_fail++; $display("FAIL beq_flags: got br=%b%b stall=%b, want 11 0", a_br, b_br, b_stall);
    end
    step();
    n_checks++;
    if (b_tgt !== 32'hF8 || a_tgt !== 64'hF8 || b_v !== 1'b1) begin
      n_fail++; $display("FAIL beq_target: got %h/%h v=%b, want f8/f8 1", b_tgt, a_tgt, b_v);
    end
    DE_V = 0;
    #1;
    n_checks++;
    if ({a_br, b_br} !== 2'b00) begin
      n_fail++; $display("FAIL br_novalid: got %b%b, want 00", a_br, b_br);
    end
  endtask

  task automatic test_random();
    logic [6:0]   ops [12] = '{LD, ST, OPR, OPI, BR, LUI, AUIPC, JAL, JALR, OP32, OPI32, UNK};
    logic [416:0] ea, aa;
    logic [224:0] eb, ab;
    logic [31:0]  ir;
    RESET = 1;
    step();
    for (int n = 0; n < 400; n++) begin
      RESET       = ($urandom_range(0, 63) == 0);
      DE_V        = ($urandom_range(0, 3) != 0);
      FLUSH       = ($urandom_range(0, 7) == 0);
      ir          = $urandom;
      ir[6:0]     = ops[$urandom_range(0, 11)];
      ir[19:15]   = 5'($urandom_range(0, 7));
      ir[24:20]   = 5'($urandom_range(0, 7));
      DE_IR       = ir;
      DE_NPC      = {$urandom, $urandom};
      EXE_V       = $urandom_range(0, 1) == 1;
      MEM_V       = $urandom_range(0, 1) == 1;
      WB_V        = $urandom_range(0, 1) == 1;
      EXE_IS_LOAD = $urandom_range(0, 2) == 0;
      EXE_DR      = 5'($urandom_range(0, 7));
      MEM_DR      = 5'($urandom_range(0, 7));
      WB_DR       = 5'($urandom_range(0, 7));
      EXE_FWD     = {$urandom, $urandom};
      MEM_FWD     = {$urandom, $urandom};
      WB_FWD      = {$urandom, $urandom};
      OUT_DE_REG_WEN = $urandom_range(0, 1) == 1;
      OUT_DE_DR   = 5'($urandom_range(0, 7));
      OUT_DE_Data = {$urandom, $urandom};
      #1;
      n_checks++;
      if ({a_stall, a_br, b_stall, b_br} !== {model_hazard(0) && !FLUSH, model_br(),
                                              model_hazard(1) && !FLUSH, model_br()}) begin
        n_fail++; $display("FAIL rnd_comb[%0d]: got stall/br a=%b%b b=%b%b, want a=%b%b b=%b%b ir=%h", n,
                           a_stall, a_br, b_stall, b_br, model_hazard(0) && !FLUSH, model_br(),
                           model_hazard(1) && !FLUSH, model_br(), DE_IR);
      end
      step();
      ea = {m_v[0], m_ir[0], m_npc[0], m_alu1[0], m_alu2[0], m_sd[0], m_tgt[0], m_maddr[0]};
      aa = {a_v, a_ir, a_npc, a_alu1, a_alu2, a_sd, a_tgt, a_maddr};
      eb = {m_v[1], m_ir[1], m_npc[1][31:0], m_alu1[1][31:0], m_alu2[1][31:0], m_sd[1][31:0],
            m_tgt[1][31:0], m_maddr[1][31:0]};
      ab = {b_v, b_ir, b_npc, b_alu1, b_alu2, b_sd, b_tgt, b_maddr};
      n_checks++;
      if (aa !== ea) begin
        n_fail++; $display("FAIL rnd_latch64[%0d]: got %h want %h", n, aa, ea);
      end
      n_checks++;
      if (ab !== eb || {a_cst, b_cst} !== 8'h00) begin
        n_fail++; $display("FAIL rnd_latch32[%0d]: got %h cst=%h%h want %h cst=00", n, ab, a_cst, b_cst, eb);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET = 0;
    idle_inputs();
    for (int i = 0; i < 32; i++) mregs[i] = 0;
    for (int k = 0; k < 2; k++) begin
      m_alu1[k] = 0; m_alu2[k] = 0; m_sd[k] = 0; m_tgt[k] = 0; m_maddr[k] = 0;
      m_npc[k] = 0; m_ir[k] = '0; m_v[k] = 1'b0;
    end
    test_reset();
    idle_inputs();
    test_exe_forward();
    idle_inputs();
    test_priority();
    idle_inputs();
    test_load_use();
    idle_inputs();
    test_x0_flush();
    idle_inputs();
    test_fwd_off_32();
    idle_inputs();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
